meter_avg_multi: RTL
====================

// Module: meter_avg_multi
// PURPOSE
// - Multi-channel sample-averaging controller for the power meter path.
// - Sits between a bank of synchronous SPI ADC front-ends (one conversion strobe shared by
//   all channels) and the host register/display logic.
// - Per burst it takes 2**AVG_LOG2 conversions, boxcar-averages every channel, and
//   publishes the averages plus a V*I power product for a selected channel pair.
// - Adds single/continuous mode, abort, conversion timeout and sample-count reporting.
// PARAMETERS
// NUM_CH       4      number of ADC channels (2..8)
// ADC_BITS     12     bits per ADC sample
// AVG_LOG2     4      log2 of samples per burst (0..8; 0 = no averaging)
// TIMEOUT_CYC  4096   max clk cycles from adc_start to adc_valid before error
// PORTS
// clk          in   1                  system clock, all logic on rising edge
// rst_n        in   1                  asynchronous active-low reset
// start        in   1                  begin burst (level sampled in IDLE)
// continuous   in   1                  1 = auto-restart next burst after done
// abort        in   1                  stop current burst, return to IDLE, no publish
// pwr_sel_v    in   3                  channel index used as voltage for power
// pwr_sel_i    in   3                  channel index used as current for power
// adc_start    out  1                  one-cycle conversion strobe to all ADCs
// adc_busy     in   1                  ADC channel 0 busy (all ADCs are synchronous)
// adc_valid    in   1                  one-cycle new-data pulse from ADC channel 0
// adc_data     in   NUM_CH*ADC_BITS    packed samples, ch k at [k*ADC_BITS +: ADC_BITS]
// busy         out  1                  high whenever state != IDLE
// avg_data     out  NUM_CH*ADC_BITS    packed averages, same packing as adc_data
// pwr_data     out  2*ADC_BITS         avg[pwr_sel_v] * avg[pwr_sel_i], unsigned
// done         out  1                  one-cycle pulse: avg_data and pwr_data updated
// err_timeout  out  1                  sticky; set on timeout, cleared by next start
// sample_cnt   out  AVG_LOG2+1         samples accumulated in current burst
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; accumulators, counters and latched samples 0.
// - States: IDLE, CONVERT, WAIT_IDLE, ACCUM, PUBLISH, POWER.
// - IDLE:
//   - start=1: clear accumulators, sample_cnt and err_timeout; pulse adc_start;
//     go to CONVERT.
// - CONVERT:
//   - Timeout counter runs from 0.
//   - adc_valid=1: latch all NUM_CH samples from adc_data; go to WAIT_IDLE.
//   - Counter reaches TIMEOUT_CYC-1 with no adc_valid: set err_timeout, go to IDLE,
//     no publish.
// - WAIT_IDLE:
//   - Hold until adc_busy=0, then go to ACCUM.
// - ACCUM (one cycle):
//   - acc[k] += latched[k]; sample_cnt += 1.
//   - If the new count < 2**AVG_LOG2: pulse adc_start, go to CONVERT.
//   - Otherwise go to PUBLISH.
// - PUBLISH:
//   - avg[k] = acc[k] >> AVG_LOG2 (truncating).
//   - Go to POWER.
// - POWER:
//   - pwr_data = avg[pwr_sel_v]*avg[pwr_sel_i]; sel inputs sampled in this state.
//   - done=1 for this cycle.
//   - continuous=1: clear acc and count, pulse adc_start, go to CONVERT.
//   - Otherwise go to IDLE.
// - Widths:
//   - acc is ADC_BITS+AVG_LOG2 bits; cannot overflow.
//   - pwr_data is full 2*ADC_BITS; no truncation.
// - Channel selects >= NUM_CH read as channel 0.
// - Latency, start to done: 2**AVG_LOG2 * (conv + WAIT_IDLE + 1) + 2 cycles.
// - abort=1 in any non-IDLE state: next state IDLE; avg_data, pwr_data and
//   err_timeout hold; no done.
// - Priority when events coincide: abort > timeout > adc_valid.
// - start while busy is ignored.
// - adc_valid outside CONVERT is ignored.
// - continuous dropped mid-burst: the current burst completes, then the block idles.
// - Async reset mid-burst: immediate return to reset state.
//   - adc_start is forced 0; the ADC finishes its own frame.
// TESTING
// - Single burst: AVG_LOG2=4, all ch const 0x800, start pulse -> 16 adc_start, one done,
//   avg=0x800 each, pwr(sel 0,1)=0x400000.
// - Averaging truncation: ch0 alternates 0x001/0x002 over 16 samples
//   -> avg0=0x001 (24>>4).
// - Full scale: all samples 0xFFF -> avg=0xFFF, pwr=0xFFE001, no wrap.
// - Timeout: never assert adc_valid -> err_timeout=1 at TIMEOUT_CYC cycles,
//   busy=0, avg unchanged.
// - Abort: assert abort after 5 samples -> IDLE next cycle, no done, sample_cnt frozen
//   at 5, prior avg held.
// - Continuous: continuous=1, start once -> back-to-back bursts with done every burst;
//   drop continuous mid-burst -> exactly one more done, then busy=0.

Source files
------------

// File: rtl/meter_avg_multi_if.sv
// ADC-side bus shared by all channels: one conversion strobe, channel-0 busy/valid and packed samples.
interface meter_avg_multi_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ADC_BITS = 12
);
    logic                         adc_start;
    logic                         adc_busy;
    logic                         adc_valid;
    logic [NUM_CH*ADC_BITS-1:0]   adc_data;

    modport master (output adc_start, input adc_busy, input adc_valid, input adc_data);
    modport slave  (input adc_start, output adc_busy, output adc_valid, output adc_data);
endinterface

// File: rtl/meter_avg_multi.sv
// Multi-channel burst averager: boxcar-averages 2**AVG_LOG2 conversions per channel
// and publishes the averages plus a V*I product for one selected channel pair.
module meter_avg_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADC_BITS    = 12,
    parameter int unsigned AVG_LOG2    = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_continuous,
    input  logic                         i_abort,
    input  logic [2:0]                   i_pwr_sel_v,
    input  logic [2:0]                   i_pwr_sel_i,
    meter_avg_multi_if.master            adc,
    output logic                         o_busy,
    output logic [NUM_CH*ADC_BITS-1:0]   o_avg_data,
    output logic [2*ADC_BITS-1:0]        o_pwr_data,
    output logic                         o_done,
    output logic                         o_err_timeout,
    output logic [AVG_LOG2:0]            o_sample_cnt
);

    localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned PWR_W = 2 * ADC_BITS;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned NSAMP = 1 << AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NSAMP);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONVERT, S_WAIT_IDLE, S_ACCUM, S_PUBLISH, S_POWER
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [ADC_BITS-1:0]         r_lat [NUM_CH];
    logic [ACC_W-1:0]            r_acc [NUM_CH];
    logic [ADC_BITS-1:0]         r_avg [NUM_CH];
    logic [CNT_W-1:0]            r_cnt;
    logic [TMR_W-1:0]            r_tmr;
    logic                        r_adc_start;
    logic                        r_busy;
    logic [NUM_CH*ADC_BITS-1:0]  r_avg_pk;
    logic [PWR_W-1:0]            r_pwr;
    logic                        r_done;
    logic                        r_err;

    logic                        w_adc_start;
    logic                        w_clr_err;
    logic                        w_clr_acc;
    logic                        w_timeout;
    logic                        w_latch;
    logic                        w_accum;
    logic                        w_publish;
    logic                        w_power;
    logic [CNT_W-1:0]            w_cnt_inc;
    logic [ADC_BITS-1:0]         w_av;
    logic [ADC_BITS-1:0]         w_ai;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and one-cycle datapath strobes; abort outranks timeout, timeout outranks valid.
    always_comb begin
        w_next      = r_state;
        w_adc_start = 1'b0;
        w_clr_err   = 1'b0;
        w_clr_acc   = 1'b0;
        w_timeout   = 1'b0;
        w_latch     = 1'b0;
        w_accum     = 1'b0;
        w_publish   = 1'b0;
        w_power     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_clr_err   = 1'b1;
                    w_clr_acc   = 1'b1;
                    w_adc_start = 1'b1;
                    w_next      = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (r_tmr == TMR_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end else if (adc.adc_valid) begin
                    w_latch = 1'b1;
                    w_next  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (i_abort)             w_next = S_IDLE;
                else if (!adc.adc_busy)  w_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_accum = 1'b1;
                    if (w_cnt_inc < CNT_FULL) begin
                        w_adc_start = 1'b1;
                        w_next      = S_CONVERT;
                    end else begin
                        w_next = S_PUBLISH;
                    end
                end
            end
            S_PUBLISH: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_publish = 1'b1;
                    w_next    = S_POWER;
                end
            end
            S_POWER: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_power = 1'b1;
                    if (i_continuous) begin
                        w_clr_acc   = 1'b1;
                        w_adc_start = 1'b1;
                        w_next      = S_CONVERT;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Power operand select; out-of-range indices fall back to channel 0.
    always_comb begin
        w_av = r_avg[0];
        w_ai = r_avg[0];
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (i_pwr_sel_v == 3'(k)) w_av = r_avg[k];
            if (i_pwr_sel_i == 3'(k)) w_ai = r_avg[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_adc_start <= 1'b0;
            r_busy      <= 1'b0;
            r_avg_pk    <= '0;
            r_pwr       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_lat[k] <= '0;
                r_acc[k] <= '0;
                r_avg[k] <= '0;
            end
        end else begin
            r_adc_start <= w_adc_start;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= w_power;
            r_tmr       <= (r_state == S_CONVERT) ? r_tmr + TMR_W'(1) : '0;

            if (w_clr_err)      r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;

            if (w_clr_acc)      r_cnt <= '0;
            else if (w_accum)   r_cnt <= w_cnt_inc;

            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (w_latch)        r_lat[k] <= adc.adc_data[k*ADC_BITS +: ADC_BITS];
                if (w_clr_acc)      r_acc[k] <= '0;
                else if (w_accum)   r_acc[k] <= r_acc[k] + ACC_W'(r_lat[k]);
                if (w_publish)      r_avg[k] <= ADC_BITS'(r_acc[k] >> AVG_LOG2);
                if (w_power)        r_avg_pk[k*ADC_BITS +: ADC_BITS] <= r_avg[k];
            end

            if (w_power) r_pwr <= PWR_W'(w_av) * PWR_W'(w_ai);
        end
    end

    assign adc.adc_start   = r_adc_start;
    assign o_busy          = r_busy;
    assign o_avg_data      = r_avg_pk;
    assign o_pwr_data      = r_pwr;
    assign o_done          = r_done;
    assign o_err_timeout   = r_err;
    assign o_sample_cnt    = r_cnt;

endmodule
